// File: rtl/instruction_fetch.sv
// Instruction fetch: sequential word fetches over a valid/ready memory port,
// in-order response buffering with PCs, and redirect-driven flush and kill.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 3
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(BUF_DEPTH - 1);

  logic [31:0]   pc_q, pc_d;
  logic          run_q;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] kill_cnt_q, kill_cnt_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [31:0]   pcq_q [BUF_DEPTH];
  logic [PW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [31:0]   buf_pc_q [BUF_DEPTH];
  logic [31:0]   buf_instr_q [BUF_DEPTH];
  logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;

  logic redir, rsp, req_fire, id_pop, rsp_keep;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // Issue: credit counts both in-flight requests and buffered entries
  assign imem_req_valid = run_q & clk_en &
                          (({1'b0, out_cnt_q} + {1'b0, occ_q}) < DEPTH_C);
  assign imem_req_addr  = pc_q;

  // Deliver: head of the buffer straight from storage
  assign id_valid = run_q & clk_en & (occ_q != '0);
  assign id_pc    = buf_pc_q[buf_rd_q];
  assign id_instr = buf_instr_q[buf_rd_q];

  assign redir    = redirect_valid & clk_en;
  assign rsp      = imem_rsp_valid & clk_en;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign id_pop   = id_valid & id_ready;
  assign rsp_keep = rsp & (kill_cnt_q == '0) & ~redir;

  always_comb begin
    pc_d       = pc_q;
    kill_cnt_d = kill_cnt_q;
    pcq_wr_d   = pcq_wr_q;
    pcq_rd_d   = pcq_rd_q;
    buf_wr_d   = buf_wr_q;
    buf_rd_d   = buf_rd_q;
    out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp);
    occ_d      = occ_q + CW'(rsp_keep) - CW'(id_pop);
    if (redir) begin
      // Everything still outstanding after this edge is stale, including
      // a request accepted this cycle at the old PC.
      pc_d       = {redirect_pc[31:2], 2'b00};
      kill_cnt_d = out_cnt_d;
      occ_d      = '0;
      pcq_wr_d   = '0;
      pcq_rd_d   = '0;
      buf_wr_d   = '0;
      buf_rd_d   = '0;
    end else begin
      if (req_fire) begin
        pc_d     = pc_q + 32'd4;
        pcq_wr_d = ptr_inc(pcq_wr_q);
      end
      if (rsp && (kill_cnt_q != '0)) kill_cnt_d = kill_cnt_q - CW'(1);
      if (rsp_keep) begin
        pcq_rd_d = ptr_inc(pcq_rd_q);
        buf_wr_d = ptr_inc(buf_wr_q);
      end
      if (id_pop) buf_rd_d = ptr_inc(buf_rd_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      run_q      <= 1'b0;
      out_cnt_q  <= '0;
      kill_cnt_q <= '0;
      occ_q      <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pcq_q[i]       <= '0;
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
      end
    end else if (clk_en) begin
      run_q      <= 1'b1;
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      kill_cnt_q <= kill_cnt_d;
      occ_q      <= occ_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
      if (req_fire && !redir) pcq_q[pcq_wr_q] <= pc_q;
      if (rsp_keep) begin
        buf_pc_q[buf_wr_q]    <= pcq_q[pcq_rd_q];
        buf_instr_q[buf_wr_q] <= imem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: in-order memory model with variable latency and
// a scoreboard of fetched {pc, instr} that a redirect flushes.
module tb_instruction_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        clk_en, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;

  instruction_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(3)) dut (
    .clk(clk), .clk_en(clk_en), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t mem_q[$];
  exp_t  exp_q[$];
  int n_checks = 0, n_fail = 0;
  int mem_lat = 1, ecyc = 0, last_due = 0, cyc = 0;
  int s_cyc;
  logic        s_req_valid, s_id_valid, s_fire, s_pop;
  logic [31:0] s_req_addr, s_id_pc, s_id_instr, last_fire_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  // One clock: drive inputs at the falling edge, sample, update model, tick.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc, input logic en);
    mreq_t m;
    exp_t  e;
    clk_en = en; id_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if (en && mem_q.size() > 0) begin
      if (mem_q[0].due <= ecyc) begin
        m = mem_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(m.addr);
      end
    end
    #1;
    s_cyc = cyc;
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
    s_id_valid = id_valid; s_id_pc = id_pc; s_id_instr = id_instr;
    s_fire = imem_req_valid & imem_req_ready;
    s_pop  = id_valid & id_ready;
    if (s_pop) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: delivered pc=%h instr=%h, expected no delivery", id_pc, id_instr);
      end else begin
        e = exp_q.pop_front();
        if (id_pc !== e.pc || id_instr !== e.instr) begin
          n_fail++;
          $display("FAIL sb_deliver: got pc=%h instr=%h, expected pc=%h instr=%h", id_pc, id_instr, e.pc, e.instr);
        end
      end
    end
    if (s_fire) begin
      m.addr = imem_req_addr;
      m.due  = ecyc + mem_lat;
      if (m.due <= last_due) m.due = last_due + 1;
      last_due = m.due;
      mem_q.push_back(m);
      e.pc = imem_req_addr; e.instr = mem_word(imem_req_addr);
      exp_q.push_back(e);
      last_fire_addr = imem_req_addr;
    end
    if (redir && en) exp_q.delete();
    @(posedge clk);
    if (en) ecyc++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic exp_rv, exp_iv;
    logic [31:0] exp_addr, exp_ipc;
    repeat (3) @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b, expected 0", imem_req_valid); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid: got %b, expected 0", id_valid); end
    n_checks++; if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL rst_req_addr: got %h, expected %h", imem_req_addr, RST_PC); end
    n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL rst_id_instr: got %h, expected 0", id_instr); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_id_pc: got %h, expected 0", id_pc); end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      exp_rv = (k >= 1);
      exp_iv = (k >= 3);
      exp_addr = RST_PC + 32'(4 * (k - 1));
      exp_ipc  = RST_PC + 32'(4 * (k - 3));
      n_checks++;
      if (s_req_valid !== exp_rv) begin n_fail++; $display("FAIL start_req_valid[%0d]: got %b, expected %b", k, s_req_valid, exp_rv); end
      if (exp_rv) begin
        n_checks++;
        if (s_req_addr !== exp_addr) begin n_fail++; $display("FAIL start_req_addr[%0d]: got %h, expected %h", k, s_req_addr, exp_addr); end
      end
      n_checks++;
      if (s_id_valid !== exp_iv) begin n_fail++; $display("FAIL start_id_valid[%0d]: got %b, expected %b", k, s_id_valid, exp_iv); end
      if (exp_iv) begin
        n_checks++;
        if (s_id_pc !== exp_ipc) begin n_fail++; $display("FAIL start_id_pc[%0d]: got %h, expected %h", k, s_id_pc, exp_ipc); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] prev;
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (s_id_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b, expected 1", i, s_id_valid); end
      n_checks++;
      if (s_id_pc !== exp_q[0].pc) begin n_fail++; $display("FAIL bp_head[%0d]: got %h, expected %h", i, s_id_pc, exp_q[0].pc); end
      if (i >= 2) begin
        n_checks++;
        if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_req[%0d]: got %b, expected 0", i, s_req_valid); end
      end
    end
    n_checks++;
    if (exp_q.size() != 3) begin n_fail++; $display("FAIL bp_inflight: got %0d issued-undelivered, expected 3", exp_q.size()); end
    n_checks++;
    if (mem_q.size() != 0) begin n_fail++; $display("FAIL bp_buffered: got %0d still outstanding, expected 0", mem_q.size()); end
    prev = exp_q[0].pc - 32'd4;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      if (s_pop) begin
        n_checks++;
        if (s_id_pc !== prev + 32'd4) begin n_fail++; $display("FAIL bp_contig[%0d]: got %h, expected %h", i, s_id_pc, prev + 32'd4); end
        prev = prev + 32'd4;
      end
    end
  endtask

  task automatic test_redirect_inflight();
    bit found;
    int req_cyc;
    mem_lat = 3;
    repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() == 2) found = 1;
      else cycle(1'b1, 1'b0, 32'h0, 1'b1);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rdi_setup: got no cycle with 2 outstanding, expected one within 20"); end
    cycle(1'b1, 1'b1, 32'h0000_2000, 1'b1);
    found = 0; req_cyc = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      if (s_fire) begin
        found = 1; req_cyc = s_cyc;
        n_checks++;
        if (s_req_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL rdi_req_addr: got %h, expected 00002000", s_req_addr); end
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rdi_req_timeout: got no request, expected one within 12 cycles"); end
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      if (s_pop) begin
        found = 1;
        n_checks++;
        if (s_id_pc !== 32'h0000_2000) begin n_fail++; $display("FAIL rdi_id_pc: got %h, expected 00002000", s_id_pc); end
        n_checks++;
        if (s_cyc - req_cyc != mem_lat + 1) begin n_fail++; $display("FAIL rdi_latency: got %0d cycles, expected %0d", s_cyc - req_cyc, mem_lat + 1); end
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rdi_pop_timeout: got no delivery, expected one within 12 cycles"); end
  endtask

  task automatic test_redirect_collide();
    bit found;
    mem_lat = 1;
    repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_q.size() == 1 && mem_q[0].due <= ecyc) found = 1;
      else cycle(1'b1, 1'b0, 32'h0, 1'b1);
    end
    cycle(1'b1, 1'b1, 32'h0000_3000, 1'b1);
    n_checks++;
    if (!(s_fire === 1'b1 && imem_rsp_valid === 1'b1)) begin n_fail++; $display("FAIL col_setup: got fire=%b rsp=%b, expected both 1", s_fire, imem_rsp_valid); end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL col_req: got valid=%b addr=%h, expected 1 00003000", s_req_valid, s_req_addr); end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (s_id_valid !== 1'b0) begin n_fail++; $display("FAIL col_killed: got id_valid=%b pc=%h, expected 0", s_id_valid, s_id_pc); end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0000_3000) begin n_fail++; $display("FAIL col_first: got valid=%b pc=%h, expected 1 00003000", s_id_valid, s_id_pc); end
  endtask

  task automatic test_misaligned_wrap();
    logic [31:0] exp_a;
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL mis_req: got valid=%b addr=%h, expected 1 00000100", s_req_valid, s_req_addr); end
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    exp_a = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== exp_a) begin n_fail++; $display("FAIL wrap_req[%0d]: got valid=%b addr=%h, expected 1 %h", k, s_req_valid, s_req_addr, exp_a); end
      exp_a = exp_a + 32'd4;
    end
    repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_clk_en();
    logic [31:0] exp_addr, exp_head;
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    exp_addr = last_fire_addr + 32'd4;
    exp_head = exp_q[0].pc;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      n_checks++;
      if (s_req_valid !== 1'b0 || s_id_valid !== 1'b0) begin n_fail++; $display("FAIL ce_valids[%0d]: got req=%b id=%b, expected 0 0", i, s_req_valid, s_id_valid); end
      n_checks++;
      if (s_req_addr !== exp_addr) begin n_fail++; $display("FAIL ce_addr[%0d]: got %h, expected %h", i, s_req_addr, exp_addr); end
      n_checks++;
      if (s_id_pc !== exp_head) begin n_fail++; $display("FAIL ce_head[%0d]: got %h, expected %h", i, s_id_pc, exp_head); end
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== exp_addr) begin n_fail++; $display("FAIL ce_resume_req: got valid=%b addr=%h, expected 1 %h", s_req_valid, s_req_addr, exp_addr); end
    n_checks++;
    if (s_id_valid !== 1'b1 || s_id_pc !== exp_head) begin n_fail++; $display("FAIL ce_resume_id: got valid=%b pc=%h, expected 1 %h", s_id_valid, s_id_pc, exp_head); end
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valids: got req=%b id=%b, expected 0 0", imem_req_valid, id_valid); end
    n_checks++;
    if (imem_req_addr !== RST_PC || id_pc !== 32'h0) begin n_fail++; $display("FAIL mid_rst_state: got addr=%h id_pc=%h, expected %h 0", imem_req_addr, id_pc, RST_PC); end
    mem_q.delete();
    exp_q.delete();
    last_due = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_run_edge: got %b, expected 0", s_req_valid); end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== RST_PC) begin n_fail++; $display("FAIL mid_restart: got valid=%b addr=%h, expected 1 %h", s_req_valid, s_req_addr, RST_PC); end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (s_id_valid !== 1'b1 || s_id_pc !== RST_PC) begin n_fail++; $display("FAIL mid_first_id: got valid=%b pc=%h, expected 1 %h", s_id_valid, s_id_pc, RST_PC); end
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; id_ready = 1'b1; imem_req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    last_fire_addr = '0;
    test_reset();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_misaligned_wrap();
    test_clk_en();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
